// File: rtl/priority_arbiter_4.sv
// priority_arbiter_4
//   Four-requester arbiter that grants ownership of one shared resource.
//   The selection policy is either fixed priority (req[3] highest) or
//   round-robin. An owner keeps the grant while it holds its request bit,
//   for at most MAX_HOLD consecutive cycles. When that limit is reached,
//   the grant is forcibly re-arbitrated and a one-cycle preempt pulse is
//   raised.
//
// Parameters
//   RR_MODE   : 0 = fixed priority, 1 = round-robin
//   MAX_HOLD  : maximum consecutive grant cycles per ownership (2..255)
//
// Ports
//   clk       : rising-edge clock
//   rst       : asynchronous active-high reset
//   req[3:0]  : request vector, one bit per requester
//   gnt[3:0]  : registered one-hot grant, zero when there is no owner
//   gnt_id    : registered index of the owner, held while gnt_valid = 0
//   gnt_valid : registered, equals |gnt
//   preempt   : one-cycle registered pulse on a MAX_HOLD timeout
module priority_arbiter_4 #(
    parameter int RR_MODE  = 0,
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_id,
    output logic       gnt_valid,
    output logic       preempt
);

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state, state_nxt;
    logic [1:0] last_id, last_id_nxt;
    logic [7:0] hold_cnt, hold_cnt_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_id_nxt;
    logic       gnt_valid_nxt;
    logic       preempt_nxt;

    logic       owner_req;
    logic       timeout;
    logic [3:0] cand;
    logic [1:0] win_id;

    // Highest set index wins.
    function automatic logic [1:0] pick_fixed(input logic [3:0] c);
        logic [1:0] w;
        w = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) w = 2'(i);
        end
        return w;
    endfunction

    // Search order is last-1, last-2, last-3, then last itself (mod 4).
    // The loop walks from lowest to highest priority, so the final
    // overwrite is the winner. The caller guarantees that c is non-zero.
    function automatic logic [1:0] pick_rr(input logic [3:0] c, input logic [1:0] last);
        logic [1:0] w;
        logic [1:0] idx;
        w = last;
        for (int k = 3; k >= 1; k--) begin
            idx = last - 2'(k);
            if (c[idx]) w = idx;
        end
        return w;
    endfunction

    // While in OWN, last_id always names the current owner.
    always_comb begin
        owner_req = req[gnt_id];
        timeout   = (state == OWN) && owner_req && (hold_cnt == HOLD_LAST);
        cand      = timeout ? (req & ~(4'b0001 << gnt_id)) : req;
        win_id    = (RR_MODE != 0) ? pick_rr(cand, last_id) : pick_fixed(cand);
    end

    // State register, with all outputs registered alongside it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            last_id   <= 2'b00;
            hold_cnt  <= 8'd0;
            gnt       <= 4'b0000;
            gnt_id    <= 2'b00;
            gnt_valid <= 1'b0;
            preempt   <= 1'b0;
        end else begin
            state     <= state_nxt;
            last_id   <= last_id_nxt;
            hold_cnt  <= hold_cnt_nxt;
            gnt       <= gnt_nxt;
            gnt_id    <= gnt_id_nxt;
            gnt_valid <= gnt_valid_nxt;
            preempt   <= preempt_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        logic arb;
        arb          = 1'b0;
        state_nxt    = state;
        last_id_nxt  = last_id;
        hold_cnt_nxt = hold_cnt;
        preempt_nxt  = 1'b0;
        case (state)
            IDLE: begin
                arb = |req;
            end
            OWN: begin
                if (!owner_req) begin
                    // Release: hand over directly, or go idle if nobody waits.
                    if (req == 4'b0000) state_nxt = IDLE;
                    else                arb       = 1'b1;
                end else if (timeout) begin
                    preempt_nxt = 1'b1;
                    // With no competitor, the owner keeps the grant with a fresh count.
                    if (cand == 4'b0000) hold_cnt_nxt = 8'd0;
                    else                 arb          = 1'b1;
                end else begin
                    hold_cnt_nxt = hold_cnt + 8'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (arb) begin
            state_nxt    = OWN;
            last_id_nxt  = win_id;
            hold_cnt_nxt = 8'd0;
        end
    end

    // Output logic (values loaded into the output registers).
    always_comb begin
        gnt_valid_nxt = (state_nxt == OWN);
        gnt_id_nxt    = gnt_valid_nxt ? last_id_nxt : gnt_id;
        gnt_nxt       = gnt_valid_nxt ? (4'b0001 << last_id_nxt) : 4'b0000;
    end

endmodule

// File: tb/tb_priority_arbiter_4.sv
module tb_priority_arbiter_4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req_f, req_r;
    logic [3:0] gnt_f, gnt_r;
    logic [1:0] gnt_id_f, gnt_id_r;
    logic       gnt_valid_f, gnt_valid_r;
    logic       preempt_f, preempt_r;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0: fixed priority, MAX_HOLD = 4
    priority_arbiter_4 #(.RR_MODE(0), .MAX_HOLD(4)) u_fix (
        .clk(clk), .rst(rst), .req(req_f), .gnt(gnt_f),
        .gnt_id(gnt_id_f), .gnt_valid(gnt_valid_f), .preempt(preempt_f)
    );

    // Instance 1: round-robin, MAX_HOLD = 2
    priority_arbiter_4 #(.RR_MODE(1), .MAX_HOLD(2)) u_rr (
        .clk(clk), .rst(rst), .req(req_r), .gnt(gnt_r),
        .gnt_id(gnt_id_r), .gnt_valid(gnt_valid_r), .preempt(preempt_r)
    );

    // Reference model: owner index (-1 = none), cycles held, last winner
    int   m_owner[2];
    int   m_held[2];
    int   m_last[2];
    int   m_gid[2];
    logic m_pre[2];

    function automatic int hold_limit(input int d);
        return (d == 0) ? 4 : 2;
    endfunction

    function automatic int pick(input int d, input logic [3:0] c);
        if (d == 1) begin
            for (int k = 1; k <= 4; k++) begin
                int idx;
                idx = (m_last[d] - k + 8) % 4;
                if (c[idx]) return idx;
            end
        end else begin
            for (int i = 3; i >= 0; i--) if (c[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_owner[d] = -1; m_held[d] = 0; m_last[d] = 0; m_gid[d] = 0; m_pre[d] = 1'b0;
        end
    endtask

    task automatic grant(input int d, input int w);
        m_owner[d] = w; m_last[d] = w; m_gid[d] = w; m_held[d] = 0;
    endtask

    task automatic model_step(input int d, input logic [3:0] r);
        logic [3:0] c;
        m_pre[d] = 1'b0;
        if (m_owner[d] < 0) begin
            if (r != 4'b0) grant(d, pick(d, r));
        end else if (!r[m_owner[d]]) begin
            if (r == 4'b0) m_owner[d] = -1;
            else           grant(d, pick(d, r));
        end else if (m_held[d] == hold_limit(d) - 1) begin
            m_pre[d] = 1'b1;
            c = r;
            c[m_owner[d]] = 1'b0;
            if (c == 4'b0) m_held[d] = 0;
            else           grant(d, pick(d, c));
        end else begin
            m_held[d]++;
        end
    endtask

    function automatic logic [3:0] exp_gnt(input int d);
        return (m_owner[d] < 0) ? 4'b0000 : (4'b0001 << m_owner[d]);
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_dut(input int d, input logic [3:0] g, input logic [1:0] gid,
                             input logic gv, input logic pr, input logic [3:0] r);
        string p;
        p = (d == 0) ? "fix" : "rr";
        check({p, ".gnt"},       8'(g),  8'(exp_gnt(d)));
        check({p, ".gnt_id"},    8'(gid), 8'(m_gid[d]));
        check({p, ".gnt_valid"}, 8'(gv), 8'(m_owner[d] >= 0));
        check({p, ".preempt"},   8'(pr), 8'(m_pre[d]));
        check({p, ".onehot0"},   8'($onehot0(g)), 8'd1);
        check({p, ".valid_or"},  8'(gv), 8'(|g));
        check({p, ".gnt_to_req"}, 8'(g & ~r), 8'd0);
    endtask

    // One clock: capture the inputs present at the edge, advance the model, check #1 later.
    task automatic tick();
        logic [3:0] rf, rr;
        rf = req_f;
        rr = req_r;
        @(posedge clk);
        model_step(0, rf);
        model_step(1, rr);
        #1;
        check_dut(0, gnt_f, gnt_id_f, gnt_valid_f, preempt_f, rf);
        check_dut(1, gnt_r, gnt_id_r, gnt_valid_r, preempt_r, rr);
    endtask

    // Assert reset between edges and check that the outputs clear before any edge.
    task automatic async_reset();
        #2 rst = 1'b1;
        #1;
        check("rst.gnt_f",       8'(gnt_f), 8'd0);
        check("rst.gnt_valid_f", 8'(gnt_valid_f), 8'd0);
        check("rst.gnt_id_f",    8'(gnt_id_f), 8'd0);
        check("rst.preempt_f",   8'(preempt_f), 8'd0);
        check("rst.gnt_r",       8'(gnt_r), 8'd0);
        check("rst.gnt_valid_r", 8'(gnt_valid_r), 8'd0);
        check("rst.gnt_id_r",    8'(gnt_id_r), 8'd0);
        check("rst.preempt_r",   8'(preempt_r), 8'd0);
        model_reset();
        #2 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int rr_seq[10];
        int rr_pre[10];
        rr_seq = '{3, 3, 2, 2, 1, 1, 0, 0, 3, 3};
        rr_pre = '{0, 0, 1, 0, 1, 0, 1, 0, 1, 0};
        rst   = 1'b1;
        req_f = 4'b0000;
        req_r = 4'b0000;
        model_reset();
        async_reset();

        // Idle with no requests
        tick();
        tick();

        // Fixed priority with direct handover on release
        req_f = 4'b0101;
        tick();
        check("fix.first_gnt", 8'(gnt_f), 8'h04);
        check("fix.first_id",  8'(gnt_id_f), 8'd2);
        req_f = 4'b0001;
        tick();
        check("fix.handover_gnt",   8'(gnt_f), 8'h01);
        check("fix.handover_valid", 8'(gnt_valid_f), 8'd1);
        req_f = 4'b0000;
        tick();
        check("fix.idle_gnt", 8'(gnt_f), 8'h00);
        check("fix.idle_id_hold", 8'(gnt_id_f), 8'd0);

        // Round-robin rotation starting from reset
        req_r = 4'b1111;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("rr.seq%0d", k), 8'(gnt_id_r), 8'(rr_seq[k]));
            check($sformatf("rr.pre%0d", k), 8'(preempt_r), 8'(rr_pre[k]));
        end
        req_r = 4'b0000;
        tick();

        // Lone requester times out repeatedly and is re-granted each time
        req_f = 4'b1000;
        for (int k = 1; k <= 13; k++) begin
            tick();
            check($sformatf("fix.solo_gnt%0d", k), 8'(gnt_f), 8'h08);
            check($sformatf("fix.solo_pre%0d", k), 8'(preempt_f),
                  8'((k == 5) || (k == 9) || (k == 13)));
        end
        req_f = 4'b0000;
        tick();

        // Timeout hands over to a competitor, then release returns ownership
        req_f = 4'b1001;
        for (int k = 1; k <= 6; k++) begin
            tick();
            check($sformatf("fix.comp_id%0d", k), 8'(gnt_id_f), 8'((k <= 4) ? 3 : 0));
            check($sformatf("fix.comp_pre%0d", k), 8'(preempt_f), 8'(k == 5));
        end
        req_f = 4'b1000;
        tick();
        check("fix.comp_back", 8'(gnt_f), 8'h08);
        req_f = 4'b0000;
        tick();

        // Asynchronous reset mid-grant
        req_f = 4'b0010;
        tick();
        check("fix.pre_rst_gnt", 8'(gnt_f), 8'h02);
        async_reset();
        tick();
        check("fix.post_rst_gnt", 8'(gnt_f), 8'h02);
        check("fix.post_rst_pre", 8'(preempt_f), 8'd0);

        // Randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) req_f = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) req_r = 4'($urandom_range(0, 15));
            if (n == 200) async_reset();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
